// File: rtl/pc_unit.sv
// pc_unit: fetch-side PC stage (IF PC, IF/ID PC, next-PC select, branch statistics)
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_stall                 freezes all state
//   i_br_d, i_cmp_y         conditional branch in D and its comparator result
//   i_imm16_d               branch offset field
//   i_j_d, i_index26_d      j/jal request and jump index
//   i_jr_d, i_rs_fwd_d      jr/jalr request and forwarded rs value
//   o_pc_f, o_pc_d, o_pc8_d fetch PC, D-stage PC, D-stage link address
//   o_valid_d, o_adel_f     D holds a real instruction, fetch address misaligned
//   o_br_cnt, o_br_taken_cnt retired / taken conditional branch counters
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_br_d,
    input  logic        i_cmp_y,
    input  logic [15:0] i_imm16_d,
    input  logic        i_j_d,
    input  logic [25:0] i_index26_d,
    input  logic        i_jr_d,
    input  logic [31:0] i_rs_fwd_d,
    output logic [31:0] o_pc_f,
    output logic [31:0] o_pc_d,
    output logic [31:0] o_pc8_d,
    output logic        o_valid_d,
    output logic        o_adel_f,
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_br_taken_cnt
);
    logic [31:0] r_pc_f, r_pc_d, r_br_cnt, r_br_taken_cnt;
    logic        r_valid_d;
    logic        w_redirect;
    logic [31:0] w_br_target, w_next_pc;

    assign w_redirect  = r_valid_d & ~i_stall;
    assign w_br_target = r_pc_d + 32'd4 + {{14{i_imm16_d[15]}}, i_imm16_d, 2'b00};

    // if-chain so an unknown cmp_y falls through to the sequential path
    always_comb begin
        w_next_pc = r_pc_f + 32'd4;
        if (w_redirect & i_jr_d)
            w_next_pc = i_rs_fwd_d;
        else if (w_redirect & i_j_d)
            w_next_pc = {r_pc_f[31:28], i_index26_d, 2'b00};
        else if (w_redirect & i_br_d & i_cmp_y)
            w_next_pc = w_br_target;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc_f         <= RESET_PC;
            r_pc_d         <= '0;
            r_valid_d      <= 1'b0;
            r_br_cnt       <= '0;
            r_br_taken_cnt <= '0;
        end else if (!i_stall) begin
            r_pc_f    <= w_next_pc;
            r_pc_d    <= r_pc_f;
            r_valid_d <= 1'b1;
            if (r_valid_d & i_br_d) begin
                r_br_cnt <= r_br_cnt + 32'd1;
                if (i_cmp_y)
                    r_br_taken_cnt <= r_br_taken_cnt + 32'd1;
            end
        end
    end

    assign o_pc_f         = r_pc_f;
    assign o_pc_d         = r_pc_d;
    assign o_pc8_d        = r_pc_d + 32'd8;
    assign o_valid_d      = r_valid_d;
    assign o_adel_f       = |r_pc_f[1:0];
    assign o_br_cnt       = r_br_cnt;
    assign o_br_taken_cnt = r_br_taken_cnt;
endmodule
